stage_monitor: RTL and testbench
================================

# stage_monitor

Synthesizable, multi-channel successor to the simulation-only stage monitor used in our Caravel freerun benches. It watches CHANNELS stage-code buses plus error lines (typically driven by firmware through mprj_io), samples them on a programmable prescaler tick, and runs a per-channel pass/fail/timeout state machine. Every stage change is logged into an event FIFO with valid/ready readout. It sits in the user project area beside the core under test, so silicon bring-up gets the same verdicts the bench prints.

## Interface
- CHANNELS, 2: number of monitored channels (1..8)
- STAGE_W, 8: stage code width
- START_CODE, 8'hFF: code that arms a channel
- PASS_CODE, 8'hFE: code that signals pass
- SAMPLE_DIV, 100: clocks per sample tick (≥ CHANNELS+1)
- TIMEOUT_TICKS, 8000: ticks without stage change before timeout
- FIFO_DEPTH, 8: event FIFO entries (power of two)
- clock  in  1  system clock
- resetb  in  1  asynchronous, active-low reset
- stage_i  in  CHANNELS*STAGE_W  stage codes, channel c at [c*STAGE_W +: STAGE_W]; synchronous to clock
- error_i  in  CHANNELS  per-channel error flags; synchronous
- clear_i  in  CHANNELS  per-channel single-cycle clear of a terminal state
- status_o  out  CHANNELS*3  per-channel state encoding
- all_pass_o  out  1  every channel in PASS
- any_fail_o  out  1  any channel in FAIL or TIMEOUT
- ev_valid_o  out  1  FIFO head valid
- ev_ready_i  in  1  consumer accepts head
- ev_channel_o  out  clog2(CHANNELS) (min 1)  head channel index
- ev_stage_o  out  STAGE_W  head stage code
- overflow_o  out  1  sticky: an event was dropped; cleared only by reset

## Operation
- Prescaler counts 0..SAMPLE_DIV-1; tick is high while count == SAMPLE_DIV-1. All channel logic advances only on tick edges.
- Per-channel FSM: IDLE, RUN, PASS, FAIL, TIMEOUT; encodings 0..4.
- IDLE: sampled stage == START_CODE → RUN; last_stage := START_CODE; timeout counter := 0; event queued. Other codes and error are ignored.
- RUN, evaluated in priority order: error → FAIL; stage == PASS_CODE → PASS (event queued); stage ≠ last_stage → stay RUN, queue event, update last_stage, counter := 0; otherwise counter+1, and reaching TIMEOUT_TICKS → TIMEOUT.
- PASS/FAIL/TIMEOUT are sticky. clear_i[c] moves any state → IDLE on any clock edge, with no tick required. clear takes priority over a same-edge tick transition.
- Event arbitration: each channel has a pending flag plus a captured stage. On each clock, the lowest-index pending channel is pushed and its pending flag cleared. A new event on a still-pending channel overwrites the captured stage and sets overflow_o.
- FIFO full at push time, with no pop in the same cycle: event dropped, overflow_o := 1. Push and pop in the same cycle while full: both succeed.
- all_pass_o and any_fail_o are combinational from registered states.

## Timing
- Reset values: prescaler 0, all FSMs IDLE (status_o all 0), counters 0, pending 0, FIFO empty, ev_valid_o 0, ev_channel_o/ev_stage_o 0, overflow_o 0, all_pass_o 0, any_fail_o 0.
- Tick edge E0: FSM update and pending set. E1: push into FIFO. ev_valid_o is high in the cycle after E1, so latency is 2 clocks for an uncontested event.
- k simultaneous events reach the FIFO on E1..Ek.
- The FIFO head is presented combinationally from storage. A pop occurs on an edge with ev_valid_o & ev_ready_i, and the next entry is visible immediately after that edge.
- Reset asserted mid-operation clears everything asynchronously. The first tick after release is SAMPLE_DIV clocks later.

## Structure
- Package stage_monitor_pkg holds the state enum (ST_IDLE..ST_TIMEOUT), the event struct {channel, stage}, and the default START/PASS codes.
- Sub-module stage_event_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, and wrap-around pointers plus a count of width clog2(DEPTH)+1.
- The top level instantiates a generate loop of per-channel FSM/counter logic, the prescaler, and a priority arbiter.

## Test plan
- Single channel with SAMPLE_DIV=4: drive stage 0xFF, then 0x00, 0x01, 0x02, then 0xFE. Required: events (0,FF),(0,00),(0,01),(0,02),(0,FE) in order; status PASS; all_pass_o=1.
- Error priority: in RUN, assert error together with stage 0xFE on the same tick. Required: FAIL, any_fail_o=1, no FE event.
- Timeout with TIMEOUT_TICKS=5: arm, then hold stage constant. Required: TIMEOUT exactly on the 5th tick after the last change. clear_i returns the channel to IDLE on the next edge.
- Simultaneous events, CHANNELS=4: all channels write 0xFF on the same tick. Required: ev_channel_o sequence 0,1,2,3 with pushes on E1..E4.
- Overflow with FIFO_DEPTH=2 and ev_ready_i=0: generate 3 events. Required: 2 retained, overflow_o=1 and sticky. Then drain with ready=1: exactly 2 pops, then ev_valid_o=0.
- Reset mid-run: assert resetb low between E0 and E1. Required: all outputs at reset values and no event emitted.

Source files
------------

// File: rtl/stage_monitor_pkg.sv
// Shared types for the stage monitor: channel states, event record, default codes.
// Channel and stage fields of ev_t are sized for the widest supported build (8 channels, 8-bit codes).
package stage_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   localparam int EV_CH_W    = 3;
   localparam int EV_STAGE_W = 8;

   typedef struct packed {
      logic [EV_CH_W-1:0]    channel;
      logic [EV_STAGE_W-1:0] stage;
   } ev_t;

   localparam logic [7:0] DEF_START_CODE = 8'hFF;
   localparam logic [7:0] DEF_PASS_CODE  = 8'hFE;

endpackage

// File: rtl/stage_event_fifo.sv
// Synchronous FIFO, head shown combinationally from storage; write-to-valid latency 1 clock.
// Push is refused when full unless a pop happens on the same edge; pop on empty is ignored.
module stage_event_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   always_comb begin
      full_o   = (cnt_q == CW'(DEPTH));
      empty_o  = (cnt_q == '0);
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full_o | do_pop);
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat_i;
      end
      // Power-of-two depth lets the pointers wrap on their own.
      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   assign pop_dat_o = mem_q[rd_ptr_q];

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/stage_monitor.sv
// Multi-channel stage-code monitor: prescaled sampling, per-channel IDLE/RUN/PASS/FAIL/TIMEOUT, event log.
// Event reaches ev_valid_o 2 clocks after its tick; with ev_ready_i low the FIFO fills, then drops set overflow_o.
module stage_monitor
   import stage_monitor_pkg::*;
#(
   parameter int                 CHANNELS      = 2,
   parameter int                 STAGE_W       = 8,
   parameter logic [STAGE_W-1:0] START_CODE    = STAGE_W'(DEF_START_CODE),
   parameter logic [STAGE_W-1:0] PASS_CODE     = STAGE_W'(DEF_PASS_CODE),
   parameter int                 SAMPLE_DIV    = 100,
   parameter int                 TIMEOUT_TICKS = 8000,
   parameter int                 FIFO_DEPTH    = 8,
   localparam int                CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          clock,
   input  logic                          resetb,
   input  logic [CHANNELS*STAGE_W-1:0]   stage_i,
   input  logic [CHANNELS-1:0]           error_i,
   input  logic [CHANNELS-1:0]           clear_i,
   output logic [CHANNELS*3-1:0]         status_o,
   output logic                          all_pass_o,
   output logic                          any_fail_o,
   output logic                          ev_valid_o,
   input  logic                          ev_ready_i,
   output logic [CH_W-1:0]               ev_channel_o,
   output logic [STAGE_W-1:0]            ev_stage_o,
   output logic                          overflow_o
);

   localparam int PS_W = $clog2(SAMPLE_DIV);
   localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

   typedef struct packed {
      logic [CH_W-1:0]    channel;
      logic [STAGE_W-1:0] stage;
   } ev_pkt_t;

   logic [PS_W-1:0]    presc_q, presc_d;
   logic               tick;
   logic               ovf_q, ovf_d;

   logic [CHANNELS-1:0] pend_vec, gnt_vec, ovf_vec, pass_vec, fail_vec;
   logic [STAGE_W-1:0]  cap_arr [CHANNELS];
   logic [CH_W-1:0]     gnt_idx;
   logic                arb_vld, pop, drop, fifo_full, fifo_empty;
   ev_pkt_t             push_dat, head;

   always_comb begin
      tick    = (presc_q == PS_W'(SAMPLE_DIV - 1));
      presc_d = tick ? '0 : presc_q + PS_W'(1);
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [STAGE_W-1:0] smp;
      state_e             state_q, state_d;
      logic [STAGE_W-1:0] last_q, last_d, cap_q, cap_d;
      logic [TO_W-1:0]    cnt_q, cnt_d, cnt_inc;
      logic               pend_q, pend_d, ev_new;

      assign smp = stage_i[c*STAGE_W +: STAGE_W];

      always_comb begin
         state_d = state_q;
         last_d  = last_q;
         cnt_d   = cnt_q;
         ev_new  = 1'b0;
         cnt_inc = cnt_q + TO_W'(1);
         if (tick) begin
            case (state_q)
               ST_IDLE: begin
                  if (smp == START_CODE) begin
                     state_d = ST_RUN;
                     last_d  = START_CODE;
                     cnt_d   = '0;
                     ev_new  = 1'b1;
                  end
               end
               ST_RUN: begin
                  if (error_i[c]) begin
                     state_d = ST_FAIL;
                  end else if (smp == PASS_CODE) begin
                     state_d = ST_PASS;
                     ev_new  = 1'b1;
                  end else if (smp != last_q) begin
                     last_d = smp;
                     cnt_d  = '0;
                     ev_new = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                     if (cnt_inc == TO_W'(TIMEOUT_TICKS)) begin
                        state_d = ST_TIMEOUT;
                     end
                  end
               end
               default: ;
            endcase
         end
         // A clear on a tick edge also swallows whatever that tick would have logged.
         if (clear_i[c]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ev_new  = 1'b0;
         end
         cap_d  = ev_new ? smp : cap_q;
         pend_d = ev_new | (pend_q & ~gnt_vec[c]);
      end

      always_ff @(posedge clock or negedge resetb) begin
         if (!resetb) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
         end
      end

      assign status_o[c*3 +: 3] = state_q;
      assign pass_vec[c]        = (state_q == ST_PASS);
      assign fail_vec[c]        = (state_q == ST_FAIL) | (state_q == ST_TIMEOUT);
      assign pend_vec[c]        = pend_q;
      assign cap_arr[c]         = cap_q;
      assign ovf_vec[c]         = ev_new & pend_q & ~gnt_vec[c];
   end

   // Lowest-index pending channel wins; one push per clock.
   always_comb begin
      gnt_vec = '0;
      gnt_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pend_vec[i]) begin
            gnt_vec    = '0;
            gnt_vec[i] = 1'b1;
            gnt_idx    = CH_W'(i);
         end
      end
      arb_vld          = |pend_vec;
      push_dat.channel = gnt_idx;
      push_dat.stage   = cap_arr[gnt_idx];
   end

   assign ev_valid_o   = ~fifo_empty;
   assign pop          = ev_valid_o & ev_ready_i;
   assign drop         = arb_vld & fifo_full & ~pop;
   assign ovf_d        = ovf_q | drop | (|ovf_vec);
   assign overflow_o   = ovf_q;
   assign ev_channel_o = head.channel;
   assign ev_stage_o   = head.stage;
   assign all_pass_o   = &pass_vec;
   assign any_fail_o   = |fail_vec;

   stage_event_fifo #(
      .WIDTH ($bits(ev_pkt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .resetb     (resetb),
      .push_i     (arb_vld),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .pop_dat_o  (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         presc_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_stage_monitor.sv
// Directed bench for stage_monitor: 4 channels, 5-clock tick, 5-tick timeout, 2-entry event FIFO.
module tb_stage_monitor;
   import stage_monitor_pkg::*;

   localparam int CH = 4;
   localparam int SD = 5;

   logic          clock = 1'b0;
   logic          resetb = 1'b0;
   logic [31:0]   stage_i = '0;
   logic [3:0]    error_i = '0;
   logic [3:0]    clear_i = '0;
   logic          ev_ready_i = 1'b1;
   logic [11:0]   status_o;
   logic          all_pass_o, any_fail_o, ev_valid_o, overflow_o;
   logic [1:0]    ev_channel_o;
   logic [7:0]    ev_stage_o;

   int   n_chk = 0;
   int   n_pass = 0;
   int   ph = 0;
   ev_t  got_q[$];
   ev_t  exp_q[$];
   ev_t  mon_e;

   stage_monitor #(
      .CHANNELS      (CH),
      .STAGE_W       (8),
      .START_CODE    (8'hFF),
      .PASS_CODE     (8'hFE),
      .SAMPLE_DIV    (SD),
      .TIMEOUT_TICKS (5),
      .FIFO_DEPTH    (2)
   ) dut (
      .clock        (clock),
      .resetb       (resetb),
      .stage_i      (stage_i),
      .error_i      (error_i),
      .clear_i      (clear_i),
      .status_o     (status_o),
      .all_pass_o   (all_pass_o),
      .any_fail_o   (any_fail_o),
      .ev_valid_o   (ev_valid_o),
      .ev_ready_i   (ev_ready_i),
      .ev_channel_o (ev_channel_o),
      .ev_stage_o   (ev_stage_o),
      .overflow_o   (overflow_o)
   );

   always #5 clock = ~clock;

   // Record every head that will be popped on the following rising edge.
   always @(negedge clock) begin
      if (resetb && ev_valid_o && ev_ready_i) begin
         mon_e.channel = 3'(ev_channel_o);
         mon_e.stage   = ev_stage_o;
         got_q.push_back(mon_e);
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   task automatic exp_ev(input int ch, input int st);
      ev_t e;
      e.channel = 3'(ch);
      e.stage   = 8'(st);
      exp_q.push_back(e);
   endtask

   task automatic cmp_events(input string tag);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_ev%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   // ph mirrors the expected prescaler count before the next rising edge.
   task automatic step1();
      @(posedge clock);
      ph = (ph == SD - 1) ? 0 : ph + 1;
      #1;
   endtask

   task automatic pre_tick();
      while (ph != SD - 1) step1();
   endtask

   task automatic tick_edge();
      pre_tick();
      step1();
   endtask

   task automatic set_stage(input int c, input int v);
      stage_i[c*8 +: 8] = 8'(v);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_status"},   status_o, 0);
      chk({tag, "_all_pass"}, all_pass_o, 0);
      chk({tag, "_any_fail"}, any_fail_o, 0);
      chk({tag, "_ev_valid"}, ev_valid_o, 0);
      chk({tag, "_ev_ch"},    ev_channel_o, 0);
      chk({tag, "_ev_stage"}, ev_stage_o, 0);
      chk({tag, "_overflow"}, overflow_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk_reset_vals("rst");
      resetb = 1'b1;
      ph = 0;

      // All four channels arm on one tick, then channel 0 walks to PASS.
      for (int c = 0; c < CH; c++) set_stage(c, 'hFF);
      tick_edge();
      chk("arm_status", status_o, 'h249);
      chk("lat_e0_valid", ev_valid_o, 0);
      step1();
      chk("lat_e1_valid", ev_valid_o, 1);
      chk("arb_e1_ch", ev_channel_o, 0);
      chk("arb_e1_stage", ev_stage_o, 'hFF);
      step1();
      chk("arb_e2_ch", ev_channel_o, 1);
      step1();
      chk("arb_e3_ch", ev_channel_o, 2);
      step1();
      chk("arb_e4_ch", ev_channel_o, 3);
      set_stage(0, 'h00);
      step1();
      chk("arb_drained", ev_valid_o, 0);
      set_stage(0, 'h01);
      tick_edge();
      set_stage(0, 'h02);
      tick_edge();
      for (int c = 0; c < CH; c++) set_stage(c, 'hFE);
      tick_edge();
      chk("pass_status", status_o, 'h492);
      chk("pass_all_pass", all_pass_o, 1);
      chk("pass_any_fail", any_fail_o, 0);
      repeat (8) step1();
      for (int c = 0; c < CH; c++) exp_ev(c, 'hFF);
      exp_ev(0, 'h00);
      exp_ev(0, 'h01);
      exp_ev(0, 'h02);
      for (int c = 0; c < CH; c++) exp_ev(c, 'hFE);
      cmp_events("seq");

      clear_i = 4'hF;
      step1();
      clear_i = 4'h0;
      chk("clear_status", status_o, 0);
      chk("clear_all_pass", all_pass_o, 0);

      // Error outranks a PASS code on the same tick.
      set_stage(0, 'hFF);
      tick_edge();
      chk("err_arm", status_o[2:0], 1);
      set_stage(0, 'hFE);
      error_i = 4'h1;
      tick_edge();
      error_i = 4'h0;
      chk("err_fail", status_o[2:0], 3);
      chk("err_any_fail", any_fail_o, 1);
      repeat (4) step1();
      exp_ev(0, 'hFF);
      cmp_events("err");

      clear_i = 4'h1;
      step1();
      clear_i = 4'h0;
      chk("clr_fail_status", status_o, 0);
      chk("clr_fail_any_fail", any_fail_o, 0);

      // Timeout on channel 1, then clear, then clear colliding with an arming tick.
      set_stage(1, 'hFF);
      tick_edge();
      chk("to_arm", status_o, 'h008);
      repeat (4) tick_edge();
      chk("to_tick4", status_o, 'h008);
      tick_edge();
      chk("to_tick5", status_o, 'h020);
      chk("to_any_fail", any_fail_o, 1);
      clear_i = 4'h2;
      step1();
      clear_i = 4'h0;
      chk("to_clear", status_o, 0);
      pre_tick();
      clear_i = 4'h2;
      step1();
      clear_i = 4'h0;
      chk("clr_prio", status_o, 0);
      set_stage(1, 'h00);
      repeat (3) step1();
      exp_ev(1, 'hFF);
      cmp_events("to");

      // Overflow: three events into a 2-deep FIFO with no consumer.
      ev_ready_i = 1'b0;
      set_stage(2, 'hFF);
      tick_edge();
      step1();
      set_stage(2, 'h00);
      tick_edge();
      step1();
      chk("ovf_before", overflow_o, 0);
      chk("ovf_valid", ev_valid_o, 1);
      chk("ovf_head_ch", ev_channel_o, 2);
      chk("ovf_head_stage", ev_stage_o, 'hFF);
      set_stage(2, 'h01);
      tick_edge();
      step1();
      chk("ovf_set", overflow_o, 1);
      repeat (2) tick_edge();
      chk("ovf_sticky", overflow_o, 1);
      chk("ovf_head_kept", ev_stage_o, 'hFF);
      ev_ready_i = 1'b1;
      repeat (4) step1();
      chk("ovf_drained", ev_valid_o, 0);
      chk("ovf_after_drain", overflow_o, 1);
      exp_ev(2, 'hFF);
      exp_ev(2, 'h00);
      cmp_events("ovf");

      // Reset between E0 and E1 must lose the pending event.
      set_stage(3, 'hFF);
      pre_tick();
      step1();
      resetb = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      repeat (2) @(posedge clock);
      #1;
      resetb = 1'b1;
      ph = 0;
      repeat (4) step1();
      chk("rst_no_tick", status_o, 0);
      chk("rst_no_valid", ev_valid_o, 0);
      chk("rst_no_event", got_q.size(), 0);
      step1();
      chk("rst_first_tick", status_o, 'h200);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
